traffic_light_monitor: RTL and testbench

Passive checker on the receiving end of the four-way traffic light bus. It samples the North/East/South/West light codes once per controller step and checks that every code is legal and that no two approaches conflict. It also checks the per-approach colour sequence, the green and yellow durations, and the N→E→S→W green rotation. Violations are reported on sticky error flags. It sits beside the light controller, driven from the same 100 MHz clock, and is used both on board and in simulation as a safety watchdog.

---
 rtl/traffic_light_monitor.sv | 164 ++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive watchdog for the four-way traffic light bus: checks encoding, conflicts,
// per-approach colour sequence and durations, and the N->E->S->W green rotation.
module traffic_light_monitor #(
  parameter int GREEN_STEPS  = 2,
  parameter int YELLOW_STEPS = 1,
  parameter int CNT_W        = 4
) (
  input  logic        clk_in,
  input  logic        rstn,
  input  logic        step_en,
  input  logic [2:0]  north,
  input  logic [2:0]  east,
  input  logic [2:0]  south,
  input  logic [2:0]  west,
  input  logic        err_clr,
  output logic        err_encode,
  output logic        err_conflict,
  output logic        err_sequence,
  output logic        err_duration,
  output logic        err_order,
  output logic        err_any,
  output logic [1:0]  active_dir,
  output logic        green_valid,
  output logic [15:0] green_count
);

  localparam logic [2:0]       RED        = 3'b100;
  localparam logic [2:0]       YEL        = 3'b010;
  localparam logic [2:0]       GRN        = 3'b001;
  localparam logic [CNT_W-1:0] RUN_MAX    = '1;
  localparam logic [CNT_W-1:0] RUN_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] GREEN_RUN  = CNT_W'(GREEN_STEPS);
  localparam logic [CNT_W-1:0] YELLOW_RUN = CNT_W'(YELLOW_STEPS);

  typedef enum logic {ST_IDLE, ST_TRACK} order_state_e;

  logic [3:0][2:0] code;
  assign code = {west, south, east, north};

  logic       seeded_q, seeded_d;
  logic [3:0] legal, is_green, is_yellow;
  logic [3:0] seq_err, dur_err, g_entry, yg_entry;

  for (genvar gi = 0; gi < 4; gi++) begin : g_appr
    logic [2:0]       prev_q, prev_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic             tracked_q, tracked_d;
    logic             changed;

    assign legal[gi]     = (code[gi] == RED) || (code[gi] == YEL) || (code[gi] == GRN);
    assign is_green[gi]  = (code[gi] == GRN);
    assign is_yellow[gi] = (code[gi] == YEL);
    assign changed       = step_en && seeded_q && legal[gi] && (code[gi] != prev_q);

    // Red and green are never adjacent in a legal sequence.
    assign seq_err[gi] = changed && (((prev_q == RED) && (code[gi] == GRN)) ||
                                     ((prev_q == GRN) && (code[gi] == RED)));
    assign dur_err[gi] = changed && (((prev_q == GRN) && (run_q != GREEN_RUN)) ||
                                     ((prev_q == YEL) && tracked_q && (run_q != YELLOW_RUN)));
    assign g_entry[gi]  = changed && is_green[gi];
    assign yg_entry[gi] = g_entry[gi] && (prev_q == YEL);

    always_comb begin
      prev_d    = prev_q;
      run_d     = run_q;
      tracked_d = tracked_q;
      if (step_en && legal[gi]) begin
        if (!seeded_q) begin
          prev_d    = code[gi];
          run_d     = RUN_ONE;
          tracked_d = 1'b0;
        end else if (changed) begin
          prev_d    = code[gi];
          run_d     = RUN_ONE;
          tracked_d = 1'b1;
        end else if (run_q != RUN_MAX) begin
          run_d = run_q + RUN_ONE;
        end
      end
    end

    always_ff @(posedge clk_in) begin
      if (rstn) begin
        prev_q    <= RED;
        run_q     <= '0;
        tracked_q <= 1'b0;
      end else begin
        prev_q    <= prev_d;
        run_q     <= run_d;
        tracked_q <= tracked_d;
      end
    end
  end

  order_state_e state_q, state_d;
  logic [1:0]   last_dir_q, last_dir_d;
  logic [15:0]  count_q, count_d;
  logic [4:0]   flags_q, flags_d;
  logic         err_any_q;

  logic       conflict, enc_err, ord_err, order_chk, any_new;
  logic [1:0] entry_dir;
  logic [4:0] new_err;

  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    count_d    = count_q;
    seeded_d   = seeded_q | step_en;
    entry_dir  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (g_entry[i]) entry_dir = 2'(i);
    end

    // Two greens, or a green alongside any yellow, is a conflict.
    conflict  = step_en && (((is_green & (is_green - 4'd1)) != 4'd0) ||
                            ((is_green != 4'd0) && (is_yellow != 4'd0)));
    enc_err   = step_en && (legal != 4'hF);
    order_chk = (g_entry != 4'd0) && !conflict;
    ord_err   = order_chk && (state_q == ST_TRACK) && (entry_dir != last_dir_q + 2'd1);
    new_err   = {enc_err, conflict, |seq_err, |dur_err, ord_err};
    any_new   = |new_err;

    if (order_chk) begin
      state_d    = ST_TRACK;
      last_dir_d = entry_dir;
      if ((yg_entry != 4'd0) && !any_new && (count_q != 16'hFFFF)) begin
        count_d = count_q + 16'd1;
      end
    end

    // Set wins over a simultaneous clear.
    flags_d = (err_clr ? 5'd0 : flags_q) | new_err;
  end

  always_ff @(posedge clk_in) begin
    if (rstn) begin
      seeded_q   <= 1'b0;
      state_q    <= ST_IDLE;
      last_dir_q <= 2'd0;
      count_q    <= 16'd0;
      flags_q    <= 5'd0;
      err_any_q  <= 1'b0;
    end else begin
      seeded_q   <= seeded_d;
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      count_q    <= count_d;
      flags_q    <= flags_d;
      err_any_q  <= |flags_q;
    end
  end

  assign err_encode   = flags_q[4];
  assign err_conflict = flags_q[3];
  assign err_sequence = flags_q[2];
  assign err_duration = flags_q[1];
  assign err_order    = flags_q[0];
  assign err_any      = err_any_q;
  assign active_dir   = last_dir_q;
  assign green_valid  = (state_q == ST_TRACK);
  assign green_count  = count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios plus random
// stimulus, all compared against a colour-level reference model.
module tb_traffic_light_monitor;

  logic        clk_in = 1'b0;
  logic        rstn = 1'b1;
  logic        step_en = 1'b0;
  logic [2:0]  north = 3'b100, east = 3'b100, south = 3'b100, west = 3'b100;
  logic        err_clr = 1'b0;
  logic        err_encode, err_conflict, err_sequence, err_duration, err_order, err_any;
  logic [1:0]  active_dir;
  logic        green_valid;
  logic [15:0] green_count;

  int checks = 0;
  int errors = 0;

  traffic_light_monitor #(.GREEN_STEPS(2), .YELLOW_STEPS(1), .CNT_W(4)) dut (
    .clk_in(clk_in), .rstn(rstn), .step_en(step_en),
    .north(north), .east(east), .south(south), .west(west),
    .err_clr(err_clr),
    .err_encode(err_encode), .err_conflict(err_conflict), .err_sequence(err_sequence),
    .err_duration(err_duration), .err_order(err_order), .err_any(err_any),
    .active_dir(active_dir), .green_valid(green_valid), .green_count(green_count)
  );

  always #5 clk_in = ~clk_in;

  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

  // Reference model: colours as 0=red, 1=yellow, 2=green, -1=illegal.
  logic [4:0] m_flags;   // {encode, conflict, sequence, duration, order}
  bit         m_err_any, m_seeded, m_gv;
  int         m_prev[4], m_run[4], m_trk[4];
  int         m_last, m_cnt;

  logic [24:0] obs_w, exp_w;
  assign obs_w = {err_encode, err_conflict, err_sequence, err_duration, err_order,
                  err_any, active_dir, green_valid, green_count};
  always_comb exp_w = {m_flags, m_err_any, 2'(m_last), m_gv, 16'(m_cnt)};

  function automatic int col(input logic [2:0] c);
    if (c == R) return 0;
    if (c == Y) return 1;
    if (c == G) return 2;
    return -1;
  endfunction

  task automatic model_reset();
    m_flags = 5'd0; m_err_any = 0; m_seeded = 0; m_gv = 0; m_last = 0; m_cnt = 0;
    for (int a = 0; a < 4; a++) begin
      m_prev[a] = 0; m_run[a] = 0; m_trk[a] = 0;
    end
  endtask

  task automatic model_step(input bit st, input logic [11:0] codes, input bit clr);
    logic [4:0] ne;
    int c[4];
    int greens, yels, entry;
    bit yg, conf, old_any;
    old_any = |m_flags;
    ne = 5'd0;
    if (st) begin
      greens = 0; yels = 0; entry = -1; yg = 0;
      for (int a = 0; a < 4; a++) begin
        c[a] = col(codes[a*3 +: 3]);
        if (c[a] == 2) greens++;
        if (c[a] == 1) yels++;
        if (c[a] < 0) ne[4] = 1'b1;
      end
      conf = (greens > 1) || (greens >= 1 && yels >= 1);
      if (conf) ne[3] = 1'b1;
      for (int a = 0; a < 4; a++) begin
        if (c[a] >= 0) begin
          if (!m_seeded) begin
            m_prev[a] = c[a]; m_run[a] = 1; m_trk[a] = 0;
          end else if (c[a] == m_prev[a]) begin
            if (m_run[a] < 15) m_run[a]++;
          end else begin
            if (c[a] - m_prev[a] == 2 || m_prev[a] - c[a] == 2) ne[2] = 1'b1;
            if (m_prev[a] == 2 && m_run[a] != 2) ne[1] = 1'b1;
            if (m_prev[a] == 1 && m_trk[a] == 1 && m_run[a] != 1) ne[1] = 1'b1;
            if (c[a] == 2) begin
              entry = a; yg = (m_prev[a] == 1);
            end
            m_prev[a] = c[a]; m_run[a] = 1; m_trk[a] = 1;
          end
        end
      end
      if (m_seeded && entry >= 0 && !conf) begin
        if (m_gv && entry != (m_last + 1) % 4) ne[0] = 1'b1;
        m_last = entry; m_gv = 1;
        if (yg && ne == 5'd0 && m_cnt < 65535) m_cnt++;
      end
      m_seeded = 1;
    end
    m_flags = (clr ? 5'd0 : m_flags) | ne;
    m_err_any = old_any;
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge,
  // return 1 time unit later so outputs can be compared.
  task automatic tick(input bit st, input logic [11:0] codes, input bit clr);
    @(negedge clk_in);
    step_en = st; err_clr = clr;
    north = codes[2:0]; east = codes[5:3]; south = codes[8:6]; west = codes[11:9];
    @(posedge clk_in);
    if (rstn) model_reset();
    else model_step(st, codes, clr);
    #1;
  endtask

  function automatic logic [11:0] pack4(input logic [2:0] n, e, s, w);
    return {w, s, e, n};
  endfunction

  // Legal controller pattern, step k of the 12-step rotation.
  function automatic logic [11:0] rot_codes(input int k);
    logic [11:0] v;
    int d, ph;
    d = k / 3; ph = k % 3;
    for (int a = 0; a < 4; a++) begin
      if (a == d) v[a*3 +: 3] = (ph < 2) ? G : Y;
      else if (a == (d + 1) % 4 && ph == 2) v[a*3 +: 3] = Y;
      else v[a*3 +: 3] = R;
    end
    return v;
  endfunction

  task automatic do_reset();
    rstn = 1'b1;
    tick(0, pack4(R, R, R, R), 0);
    rstn = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    tick(1, pack4(G, G, 3'b111, Y), 1);
    tick(0, pack4(R, R, R, R), 0);
    rstn = 1'b0;
    checks++;
    if (obs_w !== 25'd0) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", obs_w, 25'd0);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    tick(1, pack4(Y, Y, Y, Y), 0);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 12; k++) begin
        for (int g = 0; g < 5; g++) begin
          tick(g == 0, rot_codes(k), 0);
          checks++;
          if (obs_w !== exp_w) begin
            errors++;
            $display("FAIL rotation r%0d k%0d c%0d: got %h want %h", r, k, g, obs_w, exp_w);
          end
        end
        checks++;
        if (k % 3 == 0 && (active_dir !== 2'(k / 3) || green_valid !== 1'b1)) begin
          errors++;
          $display("FAIL rotation_dir k%0d: got dir %0d valid %0b want dir %0d valid 1",
                   k, active_dir, green_valid, k / 3);
        end
      end
    end
    checks++;
    if (green_count !== 16'd8 || obs_w[24:19] !== 6'd0) begin
      errors++;
      $display("FAIL rotation_final: got count %0d flags %b want count 8 flags 0",
               green_count, obs_w[24:19]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tick(1, pack4(Y, Y, Y, Y), 0);
    for (int k = 0; k < 24; k++) begin
      tick(1, rot_codes(k % 12), 0);
      checks++;
      if (obs_w !== exp_w) begin
        errors++;
        $display("FAIL back_to_back k%0d: got %h want %h", k, obs_w, exp_w);
      end
    end
    checks++;
    if (green_count !== 16'd8 || err_any !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_final: got count %0d err_any %0b want 8 0", green_count, err_any);
    end
  endtask

  task automatic test_duration();
    do_reset();
    tick(1, pack4(Y, Y, Y, Y), 0);
    tick(1, rot_codes(0), 0);
    tick(1, rot_codes(1), 0);
    tick(1, rot_codes(1), 0);
    checks++;
    if (err_duration !== 1'b0 || obs_w !== exp_w) begin
      errors++;
      $display("FAIL duration_hold: got %h want %h", obs_w, exp_w);
    end
    tick(1, rot_codes(2), 0);
    checks++;
    if (obs_w[24:20] !== 5'b00010 || obs_w !== exp_w) begin
      errors++;
      $display("FAIL duration_long_green: got flags %b want 00010", obs_w[24:20]);
    end
  endtask

  task automatic test_sequence();
    do_reset();
    tick(1, pack4(Y, Y, Y, Y), 0);
    tick(1, rot_codes(0), 0);
    tick(1, rot_codes(1), 0);
    tick(1, pack4(R, R, R, R), 0);
    checks++;
    if (err_sequence !== 1'b1 || err_order !== 1'b0 || obs_w !== exp_w) begin
      errors++;
      $display("FAIL sequence_g_to_r: got %h want %h", obs_w, exp_w);
    end
    do_reset();
    tick(1, pack4(R, R, R, R), 0);
    tick(1, pack4(R, G, R, R), 0);
    checks++;
    if (err_sequence !== 1'b1 || obs_w !== exp_w) begin
      errors++;
      $display("FAIL sequence_r_to_g: got %h want %h", obs_w, exp_w);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    tick(1, pack4(Y, Y, Y, Y), 0);
    tick(1, rot_codes(0), 0);
    tick(1, pack4(G, G, R, R), 0);
    checks++;
    if (err_conflict !== 1'b1 || green_count !== 16'd1 || active_dir !== 2'd0 || obs_w !== exp_w) begin
      errors++;
      $display("FAIL conflict: got %h want conflict=1 count=1 dir=0 (%h)", obs_w, exp_w);
    end
    tick(0, pack4(R, R, R, R), 1);
    tick(0, pack4(R, R, R, R), 0);
    tick(0, pack4(R, R, R, R), 0);
    checks++;
    if (obs_w[24:19] !== 6'd0 || obs_w !== exp_w) begin
      errors++;
      $display("FAIL conflict_clear: got flags %b want 0", obs_w[24:19]);
    end
  endtask

  task automatic test_encode();
    do_reset();
    tick(1, pack4(R, R, R, R), 0);
    tick(1, pack4(R, R, R, 3'b110), 0);
    checks++;
    if (obs_w[24:20] !== 5'b10000 || obs_w !== exp_w) begin
      errors++;
      $display("FAIL encode_illegal: got flags %b want 10000", obs_w[24:20]);
    end
    tick(1, pack4(R, R, R, G), 0);
    checks++;
    if (err_sequence !== 1'b1 || err_encode !== 1'b1 || obs_w !== exp_w) begin
      errors++;
      $display("FAIL encode_hold_prev: got %h want %h", obs_w, exp_w);
    end
  endtask

  task automatic test_order();
    do_reset();
    tick(1, pack4(Y, Y, Y, Y), 0);
    tick(1, pack4(G, R, R, R), 0);
    tick(1, pack4(G, R, R, R), 0);
    tick(1, pack4(Y, R, R, R), 0);
    tick(1, pack4(R, R, Y, R), 0);
    tick(1, pack4(R, R, G, R), 0);
    checks++;
    if (err_order !== 1'b1 || active_dir !== 2'd2 || obs_w[24:20] !== 5'b00001 || obs_w !== exp_w) begin
      errors++;
      $display("FAIL order_skip: got %h want order=1 dir=2 (%h)", obs_w, exp_w);
    end
    tick(1, pack4(R, R, R, R), 1);
    checks++;
    if (err_sequence !== 1'b1 || err_order !== 1'b0 || obs_w !== exp_w) begin
      errors++;
      $display("FAIL clear_vs_set: got %h want %h", obs_w, exp_w);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    tick(1, pack4(Y, Y, Y, Y), 0);
    for (int k = 0; k < 5; k++) tick(1, rot_codes(k), 0);
    tick(1, pack4(G, G, R, R), 0);
    do_reset();
    checks++;
    if (obs_w !== 25'd0) begin
      errors++;
      $display("FAIL mid_reset: got %h want 0", obs_w);
    end
    tick(1, rot_codes(5), 0);
    tick(1, rot_codes(6), 0);
    checks++;
    if (obs_w[24:19] !== 6'd0 || active_dir !== 2'd2 || green_count !== 16'd1 || obs_w !== exp_w) begin
      errors++;
      $display("FAIL mid_reset_reseed: got %h want %h", obs_w, exp_w);
    end
  endtask

  task automatic test_random();
    logic [11:0] v;
    int p;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int a = 0; a < 4; a++) begin
        p = $urandom_range(0, 9);
        if (p < 4) v[a*3 +: 3] = R;
        else if (p < 6) v[a*3 +: 3] = Y;
        else if (p < 9) v[a*3 +: 3] = G;
        else v[a*3 +: 3] = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 99) == 0) rstn = 1'b1;
      tick($urandom_range(0, 1) == 1, v, $urandom_range(0, 11) == 0);
      rstn = 1'b0;
      checks++;
      if (obs_w !== exp_w) begin
        errors++;
        $display("FAIL random c%0d: got %h want %h", i, obs_w, exp_w);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rotation();
    test_back_to_back();
    test_duration();
    test_sequence();
    test_conflict();
    test_encode();
    test_order();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
